button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Conditioning front end for the push-button input of `datapath`. It sits between the board pin and `datapath.i_button`.
- Synchronises the asynchronous raw button into the `i_clk` domain and suppresses contact bounce.
- Drives a clean debounced level plus single-cycle press and release pulses. `datapath` therefore sees exactly one event per physical press.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops. Legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes. Default is 10 ms at 100 MHz. Legal range >= 1.
- REPEAT_DELAY, 50000000, cycles from the first press pulse to the first auto-repeat pulse. Used only with BUTTON_AUTOREPEAT_EN. Legal range >= 1.
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses. Used only with BUTTON_AUTOREPEAT_EN. Legal range >= 1.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_button_raw  in  1  raw, asynchronous, bouncing button pin.
- o_button  out  1  debounced level; connects to datapath i_button.
- o_press  out  1  one-cycle pulse on a debounced 0->1 transition (and on auto-repeat, if enabled).
- o_release  out  1  one-cycle pulse on a debounced 1->0 transition.

Behaviour:
- Interface (already decided): one clock `i_clk`; reset `i_reset` is synchronous and active-high.
- Reset: on any edge with i_reset=1:
  - all sync flops := 0
  - state := IDLE, counter := 0
  - o_button := 0, o_press := 0, o_release := 0
  - repeat counter := 0
  - Reset overrides everything, including mid-count. Any in-progress debounce or repeat is discarded.
- Synchroniser: shift chain of SYNC_STAGES flops. `sync` is the last stage. No logic is placed between stages.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1) bits. It never wraps; it is always cleared before reaching its limit.
- FSM states: IDLE (stable 0), PRESS_WAIT, PRESSED (stable 1), RELEASE_WAIT.
  - IDLE: sync=1 -> PRESS_WAIT, counter := 1. If DEBOUNCE_CYCLES=1, go directly to PRESSED instead.
  - PRESS_WAIT:
    - sync=0 -> IDLE, counter := 0 (glitch rejected, no pulse).
    - sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED, counter := 0.
    - otherwise counter += 1.
  - PRESSED: sync=0 -> RELEASE_WAIT, counter := 1. The DEBOUNCE_CYCLES=1 shortcut applies here too.
  - RELEASE_WAIT: mirror of PRESS_WAIT, returning to PRESSED on a glitch and to IDLE on completion.
- Outputs are registered:
  - o_button = 1 exactly in PRESSED and RELEASE_WAIT.
  - o_press is 1 for one cycle, on the same edge o_button rises.
  - o_release is 1 for one cycle, on the same edge o_button falls.
  - o_press and o_release are never 1 together.
- Latency: raw changes before edge N and stays stable -> o_button/pulse visible after edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Bounce: any cycle with sync equal to the current stable level restarts the count. Only an uninterrupted run of DEBOUNCE_CYCLES mismatching cycles changes o_button.
- Raw held high through reset: treated as a fresh press after reset releases. o_press fires after the normal latency.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - While in PRESSED, o_press re-pulses REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
  - The repeat counter is cleared on leaving PRESSED.
  - While in RELEASE_WAIT the repeat count pauses. It resumes if a glitch returns the FSM to PRESSED.
- Not defined: o_press fires only on the debounced 0->1 transition. Repeat logic is absent and the REPEAT_* parameters are ignored.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless noted.
1. Clean press: reset for 10 cycles, raw=1 before edge N and held -> o_button=1 and o_press=1 after edge N+5. o_press=0 after N+6. o_release stays 0.
2. Glitch: raw=1 for 3 cycles, then 0 -> o_button, o_press and o_release remain 0 throughout.
3. Release: from stable pressed, raw=0 before edge M -> o_button=0 and o_release=1 after edge M+5, for exactly one cycle.
4. Bounce: raw toggles every cycle for 6 cycles, then held 1 from edge K -> exactly one o_press, after edge K+5.
5. Reset mid-count: assert i_reset while in PRESS_WAIT with counter=2, raw still 1 -> all outputs 0 after the next edge. After deassertion, o_press fires 5 edges after the first non-reset edge.
6. Autorepeat with BUTTON_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, first press pulse at edge P, raw held -> o_press at P, P+8, P+11, P+14. Without the macro -> o_press only at P.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise and debounce a raw button, emitting a clean level plus press/release pulses.
// Optional auto-repeat of o_press while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button_raw,
  output logic o_button,
  output logic o_press,
  output logic o_release
);
  localparam int MAX_DR = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = MAX_DR > REPEAT_PERIOD ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge i_clk)
    if (i_reset) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], i_button_raw};
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  logic [CW-1:0] rcnt;
  logic rfirst;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      o_button  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt      <= '0;
      rfirst    <= 1'b1;
`endif
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state)
        IDLE:
          if (sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state    <= PRESSED;
              o_button <= 1'b1;
              o_press  <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= CW'(1);
            end
          end
        PRESS_WAIT:
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= PRESSED;
            cnt      <= '0;
            o_button <= 1'b1;
            o_press  <= 1'b1;
          end else cnt <= cnt + CW'(1);
        PRESSED:
          if (!sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state     <= IDLE;
              o_button  <= 1'b0;
              o_release <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
              rcnt      <= '0;
              rfirst    <= 1'b1;
`endif
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= CW'(1);
            end
          end else begin
`ifdef BUTTON_AUTOREPEAT_EN
            // repeat count only advances while the level is stably held
            if (rcnt == (rfirst ? RD_LAST : RP_LAST)) begin
              o_press <= 1'b1;
              rcnt    <= '0;
              rfirst  <= 1'b0;
            end else rcnt <= rcnt + CW'(1);
`endif
          end
        RELEASE_WAIT:
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            o_button  <= 1'b0;
            o_release <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt      <= '0;
            rfirst    <= 1'b1;
`endif
          end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
